// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive deserializer.
package usb_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  localparam int STUFF_ONES = 6;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/usb_rx_deserializer_if.sv
// Bit-stream, FIFO-read and status signals between the RX decoder/controller and the deserializer.
interface usb_rx_deserializer_if import usb_rx_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic             rx_start;
  logic             shift_enable;
  logic             d_orig;
  logic             eop;
  logic             r_enable;
  logic [WIDTH-1:0] rx_data;
  logic             fifo_empty;
  logic             fifo_full;
  logic             word_done;
  logic             partial_err;
  logic             overrun;
  logic             stuff_err;

  modport master (
    output rx_start, shift_enable, d_orig, eop, r_enable,
    input  rx_data, fifo_empty, fifo_full, word_done, partial_err, overrun, stuff_err
  );

  modport slave (
    input  rx_start, shift_enable, d_orig, eop, r_enable,
    output rx_data, fifo_empty, fifo_full, word_done, partial_err, overrun, stuff_err
  );
endinterface

// File: rtl/usb_rx_fifo.sv
// Show-ahead register FIFO; pointers carry an extra wrap bit to tell full from empty.
module usb_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/usb_rx_deserializer.sv
// Assembles the decoded USB bit stream LSB-first into WIDTH-bit words and buffers them.
// Define USB_RX_SR_BITSTUFF_EN to strip stuff bits internally and flag stuffing violations.
module usb_rx_deserializer import usb_rx_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 n_rst,
  usb_rx_deserializer_if.slave bus
);
  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  rx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-2:0] shreg, shreg_next;
  logic [WIDTH-1:0] word;
  logic             overrun_q, overrun_next;
  logic             word_done_q, word_done_next;
  logic             partial_q, partial_next;
  logic             push;
  logic             data_bit;
  logic             stuff_viol;
`ifdef USB_RX_SR_BITSTUFF_EN
  logic [2:0]       ones, ones_next;
  logic             stuff_q;
`endif

  // Pending bits sit in the upper positions; the incoming bit completes the word as its MSB.
  assign word = {bus.d_orig, shreg};

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    shreg_next     = shreg;
    overrun_next   = overrun_q;
    word_done_next = 1'b0;
    partial_next   = 1'b0;
    push           = 1'b0;
    data_bit       = 1'b0;
    stuff_viol     = 1'b0;
`ifdef USB_RX_SR_BITSTUFF_EN
    ones_next      = ones;
`endif
    if (bus.rx_start) begin
      state_next   = RECV;
      cnt_next     = '0;
      shreg_next   = '0;
      overrun_next = 1'b0;
`ifdef USB_RX_SR_BITSTUFF_EN
      ones_next    = '0;
`endif
    end else if (state == RECV) begin
`ifdef USB_RX_SR_BITSTUFF_EN
      if (bus.shift_enable) begin
        if (ones == 3'(STUFF_ONES)) begin
          if (bus.d_orig) stuff_viol = 1'b1;
          else            ones_next  = '0;
        end else begin
          data_bit = 1'b1;
        end
      end
`else
      data_bit = bus.shift_enable;
`endif
      if (data_bit) begin
        shreg_next = word[WIDTH-1:1];
`ifdef USB_RX_SR_BITSTUFF_EN
        ones_next  = bus.d_orig ? ones + 3'd1 : 3'd0;
`endif
        if (cnt == LAST_BIT) begin
          cnt_next       = '0;
          push           = 1'b1;
          word_done_next = 1'b1;
          if (bus.fifo_full && !bus.r_enable) overrun_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      // The same-cycle bit has already been folded into cnt_next before eop is judged.
      if (stuff_viol || bus.eop) begin
        partial_next = !stuff_viol && (cnt_next != '0);
        state_next   = IDLE;
        cnt_next     = '0;
        shreg_next   = '0;
`ifdef USB_RX_SR_BITSTUFF_EN
        ones_next    = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      overrun_q   <= 1'b0;
      word_done_q <= 1'b0;
      partial_q   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      shreg       <= shreg_next;
      overrun_q   <= overrun_next;
      word_done_q <= word_done_next;
      partial_q   <= partial_next;
    end
  end

`ifdef USB_RX_SR_BITSTUFF_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones    <= '0;
      stuff_q <= 1'b0;
    end else begin
      ones    <= ones_next;
      stuff_q <= stuff_viol;
    end
  end

  assign bus.stuff_err = stuff_q;
`else
  assign bus.stuff_err = 1'b0;
`endif

  assign bus.word_done   = word_done_q;
  assign bus.partial_err = partial_q;
  assign bus.overrun     = overrun_q;

  usb_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .pop   (bus.r_enable),
    .wdata (word),
    .rdata (bus.rx_data),
    .empty (bus.fifo_empty),
    .full  (bus.fifo_full)
  );
endmodule
